keypad_scan_rx: RTL and testbench
=================================

// Module: keypad_scan_rx
// PURPOSE
//   Input-side counterpart of the multiplexed seven-segment display scanner.
//   Drives 4 active-low column lines of a 4x4 matrix keypad, reads 4 row lines
//   and debounces each press. Each accepted press becomes one 4-bit key code,
//   delivered over a valid/ready handshake to the stopwatch control logic.
//   Runs on the same slow clock as the display refresh divider.
// PARAMETERS
//   SCAN_DIV_W    15  scan tick every 2**SCAN_DIV_W clk_slw cycles (matches display refresh)
//   DEB_CNT       4   consecutive agreeing ticks to accept a press or a release (>=1)
//   REPEAT_TICKS  64  auto-repeat interval in ticks (used only with KEYPAD_AUTOREPEAT_EN)
// PORTS
//   clk_slw    in   1  clock
//   reset      in   1  synchronous, active-high
//   row_in     in   4  row sense, active-low (pulled up off-chip); already synchronised
//   col_drv    out  4  column drive, active-low, one-hot-low
//   key_code   out  4  {row[1:0],col[1:0]} = row*4+col; stable while key_valid=1
//   key_valid  out  1  code pending
//   key_ready  in   1  consumer accepts the code (transfer = key_valid & key_ready)
//   key_held   out  1  1 while the accepted key is still physically down
//   key_ovf    out  1  1-cycle pulse: a new code was dropped because the buffer was full
// BEHAVIOUR
//   Reset values: col_drv=4'b1110, key_code=0, key_valid=0, key_held=0, key_ovf=0.
//     FSM=SCAN; tick divider, column index, debounce and repeat counters = 0.
//     Reset mid-press or mid-handshake discards the pending code; no code is emitted.
//   Tick: 1-cycle strobe when divider (SCAN_DIV_W bits) wraps from all-ones to 0.
//     row_in is sampled only on tick cycles.
//     col_drv changes only in the cycle after a tick, so rows get a full period to settle.
//   FSM:
//     SCAN: on tick, if any row low -> latch col idx + lowest-index low row,
//       deb_cnt=1, go DEBOUNCE, freeze column.
//       Else advance column 0->1->2->3->0 (wrap).
//       If DEB_CNT==1, go directly to the emit action of DEBOUNCE.
//     DEBOUNCE: on tick, if latched row still low -> deb_cnt++.
//       On reaching DEB_CNT -> emit, key_held=1, go HELD.
//       If latched row is high -> go SCAN, advance column, no emit.
//       A different row going low is ignored; only the latched row counts.
//     HELD: on tick, latched row high -> rel_cnt++, else rel_cnt=0.
//       rel_cnt==DEB_CNT -> key_held=0, go SCAN, advance column.
//   Emit = write code to the 1-entry output buffer:
//     buffer empty, or transfer in the same cycle -> key_code<=code, key_valid<=1.
//     Otherwise the new code is dropped, key_ovf pulses, and the old code is kept.
//   Transfer without emit -> key_valid<=0 next cycle; key_code holds its last value.
//   Latency: key_valid rises 1 cycle after the tick on which deb_cnt reaches DEB_CNT.
//   Counter widths: deb/rel $clog2(DEB_CNT+1); no arithmetic on key_code.
// CONFIGURATION
//   KEYPAD_AUTOREPEAT_EN defined:
//     In HELD, while the key is down, re-emit the same code every REPEAT_TICKS ticks.
//     The first repeat comes REPEAT_TICKS ticks after acceptance; same overflow rule.
//     rep_cnt clears on entry to HELD and on any release tick.
//   Not defined: one code per press; rep_cnt logic and REPEAT_TICKS are unused.
// STRUCTURE
//   keypad_pkg:
//     state enum {SCAN, DEBOUNCE, HELD}; KEY_W=4, ROWS=4, COLS=4; col one-hot-low table.
//   Sub-module keypad_tick_gen: SCAN_DIV_W divider -> tick strobe.
//     The same block is reusable for the display refresh.
//   FSM, buffer and outputs live in keypad_scan_rx.
// TESTING
//   Bench uses SCAN_DIV_W=2 (tick every 4 cycles), DEB_CNT=4, keypad model driven by col_drv.
//   1 Hold key r2/c1 low for 6 ticks, key_ready=1
//       -> exactly one pulse key_valid with key_code=4'd9; key_held=1 until 4 release ticks.
//   2 Bounce r0/c3 low for 2 ticks then high
//       -> no key_valid; column scanning resumes at c0 after the wrap.
//   3 key_ready=0; press c0/r0 then c2/r3
//       -> key_code stays 4'd0, key_valid stays 1, key_ovf pulses once for the second press.
//   4 key_ready asserted on the same cycle as the second emit
//       -> key_valid stays 1, key_code changes 0->14, no key_ovf.
//   5 Assert reset during DEBOUNCE and during pending key_valid
//       -> next cycle all outputs = reset values, col_drv=4'b1110.
//   6 (KEYPAD_AUTOREPEAT_EN, REPEAT_TICKS=8) Hold r1/c1 for 30 ticks, key_ready=1
//       -> codes 4'd5 at acceptance, then every 8 ticks; none after release.

Source files
------------

// File: rtl/keypad_scan_rx_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  // Column drive pattern per column index; entry 0 pulls column 0 low.
  localparam logic [COLS-1:0][COLS-1:0] COL_DRV_TAB = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Index of the lowest-numbered row that reads low (active-low rows).
  function automatic logic [1:0] low_row(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_rx_if.sv
// Key-code handshake between the keypad scanner and its consumer.
interface keypad_scan_rx_if;
  logic [keypad_pkg::KEY_W-1:0] key_code;
  logic                         key_valid;
  logic                         key_ready;
  logic                         key_held;
  logic                         key_ovf;

  modport master (output key_code, key_valid, key_held, key_ovf, input key_ready);
  modport slave  (input key_code, key_valid, key_held, key_ovf, output key_ready);
endinterface

// File: rtl/keypad_scan_rx_tick_gen.sv
// Free-running divider producing a one-cycle strobe every 2**DIV_W cycles.
module keypad_tick_gen #(
  parameter int unsigned DIV_W = 15
) (
  input  logic clk_slw,
  input  logic reset,
  output logic tick
);

  logic [DIV_W-1:0] div_q;

  // Divider counts up and wraps; the all-ones cycle is the strobe.
  always_ff @(posedge clk_slw) begin
    if (reset) div_q <= '0;
    else       div_q <= div_q + DIV_W'(1);
  end

  assign tick = &div_q;

endmodule

// File: rtl/keypad_scan_rx.sv
// 4x4 keypad column scanner with per-press debounce and a one-entry code buffer.
// Optional auto-repeat while a key stays down: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_rx import keypad_pkg::*; #(
  parameter int unsigned SCAN_DIV_W   = 15,
  parameter int unsigned DEB_CNT      = 4,
  parameter int unsigned REPEAT_TICKS = 64
) (
  input  logic             clk_slw,
  input  logic             reset,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_drv,
  keypad_scan_rx_if.master kbus
);

  localparam int unsigned CNT_W = $clog2(DEB_CNT + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CNT);

  logic tick;

  keypad_tick_gen #(
    .DIV_W (SCAN_DIV_W)
  ) u_tick_gen (
    .clk_slw (clk_slw),
    .reset   (reset),
    .tick    (tick)
  );

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0] deb_q, deb_d, rel_q, rel_d;
  logic [KEY_W-1:0] code_q, code_d, emit_code;
  logic             valid_q, valid_d, held_q, held_d, ovf_q, ovf_d;
  logic             emit, xfer;

  logic       any_low, row_down;
  logic [1:0] hit_row, col_next;

  assign any_low  = ~&row_in;
  assign hit_row  = low_row(row_in);
  assign row_down = ~row_in[row_q];
  assign col_next = col_q + 2'd1;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_TICKS);
  logic [REP_W-1:0] rep_q, rep_d;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_TICKS;
`endif

  // Scan/debounce/hold sequencing; everything advances only on tick cycles.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    deb_d     = deb_q;
    rel_d     = rel_q;
    held_d    = held_q;
    emit      = 1'b0;
    emit_code = {row_q, col_q};
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            row_d     = hit_row;
            deb_d     = CNT_W'(1);
            emit_code = {hit_row, col_q};
            if (DEB_CNT == 1) begin
              emit    = 1'b1;
              held_d  = 1'b1;
              rel_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = '0;
`endif
              state_d = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          // Only the latched row matters; other rows are ignored here.
          if (row_down) begin
            deb_d = deb_q + CNT_W'(1);
            if (deb_d == DEB_MAX) begin
              emit    = 1'b1;
              held_d  = 1'b1;
              rel_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = '0;
`endif
              state_d = HELD;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_next;
          end
        end
        HELD: begin
          if (!row_down) begin
            rel_d = rel_q + CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d = '0;
`endif
            if (rel_d == DEB_MAX) begin
              held_d  = 1'b0;
              state_d = SCAN;
              col_d   = col_next;
            end
          end else begin
            rel_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d = rep_q + REP_W'(1);
            if (rep_d == REP_MAX) begin
              emit  = 1'b1;
              rep_d = '0;
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // One-entry output buffer: a same-cycle transfer frees the slot for a new code.
  always_comb begin
    xfer    = valid_q & kbus.key_ready;
    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
    if (emit) begin
      if (!valid_q || xfer) begin
        code_d  = emit_code;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_slw) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      deb_q   <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      deb_q   <= deb_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      ovf_q   <= ovf_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign col_drv        = COL_DRV_TAB[col_q];
  assign kbus.key_code  = code_q;
  assign kbus.key_valid = valid_q;
  assign kbus.key_held  = held_q;
  assign kbus.key_ovf   = ovf_q;

endmodule

// File: tb/tb_keypad_scan_rx.sv
// Bench for keypad_scan_rx: keypad matrix model, tick-level reference model,
// directed table, random presses and hand-written handshake/reset sequences.
module tb_keypad_scan_rx;

  localparam int DIV_W = 2;
  localparam int DEB   = 4;
  localparam int REP   = 8;
  localparam int TPER  = 1 << DIV_W;

  logic       clk_slw = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_drv;
  logic [15:0] keys;   // keys[r*4+c] = 1 while that key is physically down

  keypad_scan_rx_if kbus();

  keypad_scan_rx #(
    .SCAN_DIV_W   (DIV_W),
    .DEB_CNT      (DEB),
    .REPEAT_TICKS (REP)
  ) dut (
    .clk_slw (clk_slw),
    .reset   (reset),
    .row_in  (row_in),
    .col_drv (col_drv),
    .kbus    (kbus)
  );

  always #5 clk_slw = ~clk_slw;

  // Passive matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_drv[c]) row_in[r] = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int ovf_cnt  = 0;
  logic [3:0] last_code;
  bit rand_ready = 0;

  // Reference model, tick-level: mode 0 = idle scan, 1 = confirming press, 2 = key held.
  int m_div, m_col, m_mode, m_row, m_cnt, m_rel, m_rep;
  bit m_valid, m_held, m_ovf, m_last_tick;
  logic [3:0] m_code;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout required DUT event within bound", name);
  endtask

  function automatic bit key_at(input int r, input int c);
    return keys[r*4+c];
  endfunction

  function automatic bit next_tick();
    return m_div == TPER - 1;
  endfunction

  task automatic model_step();
    bit tick, emit, xfer;
    int low;
    if (reset) begin
      m_div = 0; m_col = 0; m_mode = 0; m_row = 0; m_cnt = 0; m_rel = 0; m_rep = 0;
      m_valid = 0; m_held = 0; m_ovf = 0; m_code = 4'd0; m_last_tick = 0;
      return;
    end
    tick = next_tick();
    m_last_tick = tick;
    m_div = (m_div + 1) % TPER;
    xfer = m_valid && kbus.key_ready;
    emit = 0;
    if (tick) begin
      case (m_mode)
        0: begin
          low = -1;
          for (int r = 3; r >= 0; r--) if (key_at(r, m_col)) low = r;
          if (low >= 0) begin
            m_row = low; m_cnt = 1; m_mode = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
        1: begin
          if (key_at(m_row, m_col)) begin
            m_cnt++;
            if (m_cnt == DEB) begin
              emit = 1; m_held = 1; m_rel = 0; m_rep = 0; m_mode = 2;
            end
          end else begin
            m_mode = 0; m_col = (m_col + 1) % 4;
          end
        end
        default: begin
          if (!key_at(m_row, m_col)) begin
            m_rel++; m_rep = 0;
            if (m_rel == DEB) begin
              m_held = 0; m_mode = 0; m_col = (m_col + 1) % 4;
            end
          end else begin
            m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
            m_rep++;
            if (m_rep == REP) begin
              emit = 1; m_rep = 0;
            end
`endif
          end
        end
      endcase
    end
    m_ovf = 0;
    if (emit) begin
      if (!m_valid || xfer) begin
        m_code = 4'(m_row * 4 + m_col); m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  // One clock: update model from pre-edge inputs, then compare all outputs after the edge.
  task automatic step();
    logic [3:0] ecol;
    if (rand_ready) kbus.key_ready = 1'($urandom_range(0, 1));
    if (!reset && kbus.key_valid === 1'b1 && kbus.key_ready) begin
      xfer_cnt++;
      last_code = kbus.key_code;
    end
    model_step();
    @(posedge clk_slw);
    #1;
    ecol = 4'hF & ~(4'd1 << m_col);
    check("outputs{col,valid,held,ovf,code}",
          {col_drv, kbus.key_valid, kbus.key_held, kbus.key_ovf, kbus.key_code},
          {ecol, m_valid, m_held, m_ovf, m_code});
    if (kbus.key_ovf === 1'b1) ovf_cnt++;
  endtask

  task automatic wait_col(input int c);
    logic [3:0] pat;
    int g;
    pat = 4'hF & ~(4'd1 << c);
    g = 0;
    while (col_drv !== pat) begin
      if (g >= 64) begin
        expire("wait_col");
        break;
      end
      step();
      g++;
    end
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = 0;
    while (t < n) begin
      step();
      if (m_last_tick) t++;
    end
  endtask

  // Press (r,c) once its column is driven, hold for 'down' ticks, release, wait for key_held to drop.
  task automatic run_press(input int r, input int c, input int down, input int r2,
                           output int rel_ticks);
    int g;
    wait_col(c);
    keys[r*4+c] = 1'b1;
    if (r2 >= 0) keys[r2*4+c] = 1'b1;
    wait_ticks(down);
    keys = '0;
    rel_ticks = 0;
    g = 0;
    while (kbus.key_held === 1'b1) begin
      if (g >= 200) begin
        expire("release");
        break;
      end
      step();
      if (m_last_tick) rel_ticks++;
      g++;
    end
    repeat (8) step();
  endtask

  typedef struct {
    int row;
    int col;
    int down;
    int n_xfer;
    int code;
    int rel;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int rel, ovf0, t, g;
    vecs[0] = '{row: 2, col: 1, down: 6, n_xfer: 1, code: 9,  rel: 4};
    vecs[1] = '{row: 3, col: 3, down: 4, n_xfer: 1, code: 15, rel: 4};
    vecs[2] = '{row: 1, col: 0, down: 3, n_xfer: 0, code: 0,  rel: 0};
    vecs[3] = '{row: 1, col: 2, down: 5, n_xfer: 1, code: 6,  rel: 4};
    vecs[4] = '{row: 0, col: 0, down: 1, n_xfer: 0, code: 0,  rel: 0};

    reset = 1'b1;
    kbus.key_ready = 1'b1;
    keys = '0;
    last_code = 4'd0;
    repeat (3) step();
    reset = 1'b0;
    check("reset_state", {col_drv, kbus.key_valid, kbus.key_held, kbus.key_ovf, kbus.key_code},
          {4'b1110, 1'b0, 1'b0, 1'b0, 4'd0});

    // Directed table, consumer always ready.
    for (int i = 0; i < 5; i++) begin
      xfer_cnt = 0;
      run_press(vecs[i].row, vecs[i].col, vecs[i].down, -1, rel);
      check("tbl_xfers", xfer_cnt, vecs[i].n_xfer);
      if (vecs[i].n_xfer > 0) check("tbl_code", last_code, vecs[i].code);
      check("tbl_release_ticks", rel, vecs[i].rel);
    end

    // Bounce on r0/c3: no code, and the next column after the wrap is c0.
    xfer_cnt = 0;
    wait_col(3);
    keys[3] = 1'b1;
    wait_ticks(2);
    keys = '0;
    wait_ticks(1);
    check("bounce_wrap_col", col_drv, 4'b1110);
    repeat (12) step();
    check("bounce_no_code", xfer_cnt, 0);

    // Random presses, random consumer readiness; per-cycle model comparison.
    rand_ready = 1;
    repeat (50) begin
      run_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 9)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, rel);
      repeat ($urandom_range(0, 10)) step();
    end
    rand_ready = 0;
    kbus.key_ready = 1'b1;
    repeat (8) step();
    check("drain_empty", kbus.key_valid, 1'b0);

    // Consumer stalled: second code is dropped with a single overflow pulse.
    kbus.key_ready = 1'b0;
    ovf_cnt = 0;
    run_press(0, 0, 5, -1, rel);
    check("stall_first_ovf", ovf_cnt, 0);
    check("stall_first_valid", kbus.key_valid, 1'b1);
    run_press(3, 2, 5, -1, rel);
    check("stall_second_ovf", ovf_cnt, 1);
    check("stall_code_kept", kbus.key_code, 4'd0);
    check("stall_valid_kept", kbus.key_valid, 1'b1);

    // Transfer coinciding with emit: slot refilled, no overflow.
    ovf0 = ovf_cnt;
    wait_col(2);
    keys[14] = 1'b1;
    t = 0;
    g = 0;
    while (t < DEB && g < 100) begin
      kbus.key_ready = next_tick() && (t == DEB - 1);
      if (kbus.key_ready) check("swap_code_before", kbus.key_code, 4'd0);
      step();
      if (m_last_tick) t++;
      g++;
    end
    if (g >= 100) expire("swap_emit");
    kbus.key_ready = 1'b0;
    check("swap_valid", kbus.key_valid, 1'b1);
    check("swap_code", kbus.key_code, 4'd14);
    check("swap_no_ovf", ovf_cnt, ovf0);
    keys = '0;
    wait_ticks(DEB + 2);

    // Reset while confirming a press and with a code pending.
    wait_col(1);
    keys[5] = 1'b1;
    wait_ticks(2);
    reset = 1'b1;
    keys = '0;
    step();
    check("reset_mid_debounce",
          {col_drv, kbus.key_valid, kbus.key_held, kbus.key_ovf, kbus.key_code},
          {4'b1110, 1'b0, 1'b0, 1'b0, 4'd0});
    reset = 1'b0;
    wait_ticks(6);
    check("no_code_after_reset", kbus.key_valid, 1'b0);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat: acceptance plus repeats 8, 16, 24 ticks later within a 30-tick hold.
    kbus.key_ready = 1'b1;
    xfer_cnt = 0;
    last_code = 4'd0;
    run_press(1, 1, 30, -1, rel);
    check("repeat_xfers", xfer_cnt, 4);
    check("repeat_code", last_code, 4'd5);
    xfer_cnt = 0;
    wait_ticks(10);
    check("repeat_none_after_release", xfer_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
